// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM encoding,
// the bundle of pipeline-register controls and its canned NOP-bubble patterns.
package hazard_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_bubble;
    logic mem_wb_bubble;
    logic mdu_start;
  } pipe_ctrl_t;

  // Free-running pipeline: every register loads, nothing is squashed.
  localparam pipe_ctrl_t CTRL_DEFAULT = '{
    pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_bubble: 1'b0,
    mem_wb_bubble: 1'b0, mdu_start: 1'b0
  };

  // Data-memory wait: everything frozen, WB receives a NOP bubble.
  localparam pipe_ctrl_t CTRL_MEM_FREEZE = '{
    pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_bubble: 1'b0,
    mem_wb_bubble: 1'b1, mdu_start: 1'b0
  };

  // MUL/DIV occupying EX: front end frozen, MEM receives a NOP bubble.
  localparam pipe_ctrl_t CTRL_MDU_STALL = '{
    pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_bubble: 1'b1,
    mem_wb_bubble: 1'b0, mdu_start: 1'b0
  };

  // A load in EX feeding a source the ID instruction really reads; x0 never hazards.
  function automatic logic load_use_hit(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] rs1,
    input logic       uses_rs1,
    input logic [4:0] rs2,
    input logic       uses_rs2
  );
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Stall and flush performance counters: wrapping, with increment enables and a
// synchronous clear that dominates.
module hazard_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_stall_inc,
  input  logic             i_flush_inc,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_stall_inc) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (i_flush_inc) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_stall_cycles = r_stall_cnt;
  assign o_flush_count  = r_flush_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// In-order pipeline hazard controller: load-use interlock, EX branch flush,
// MUL/DIV start/done handshake and data-memory freeze, with perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_is_mdu,
  input  logic             mdu_done,
  input  logic             EX_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Bubble,
  output logic             MEM_WB_Bubble,
  output logic             mdu_start,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_e     r_state;
  state_e     w_next_state;
  logic       r_done_pend;
  logic       w_next_done_pend;
  logic       w_mem_wait;
  logic       w_load_use;
  logic       w_mdu_release;
  logic       w_flush_inc;
  logic       w_stall_inc;
  pipe_ctrl_t w_ctrl;

  assign w_mem_wait    = dmem_req && !dmem_ready;
  assign w_load_use    = load_use_hit(ID_EX_MemRead, ID_EX_rd, ID_rs1, ID_uses_rs1,
                                      ID_rs2, ID_uses_rs2);
  assign w_mdu_release = (r_state == MDU_BUSY) && (mdu_done || r_done_pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_done_pend <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_done_pend <= w_next_done_pend;
    end
  end

  // A done pulse only matters while an operation is outstanding, so a stray
  // pulse after a reset-abandoned operation cannot latch into done_pend.
  always_comb begin
    // NOTE: defaults first so every path assigns every variable (no latches).
    w_next_state     = r_state;
    w_next_done_pend = r_done_pend;
    if (w_mem_wait) begin
      if ((r_state == MDU_BUSY) && mdu_done) w_next_done_pend = 1'b1;
    end else if (r_state == MDU_BUSY) begin
      if (w_mdu_release) begin
        w_next_state     = RUN;
        w_next_done_pend = 1'b0;
      end
    end else if (ID_EX_is_mdu) begin
      w_next_state = MDU_BUSY;
    end
  end

  always_comb begin
    w_ctrl      = CTRL_DEFAULT;
    w_flush_inc = 1'b0;
    if (!rst) begin
      if (w_mem_wait) begin
        w_ctrl = CTRL_MEM_FREEZE;
      end else if (r_state == MDU_BUSY) begin
        if (!w_mdu_release) w_ctrl = CTRL_MDU_STALL;
      end else if (ID_EX_is_mdu) begin
        w_ctrl           = CTRL_MDU_STALL;
        w_ctrl.mdu_start = 1'b1;
      end else if (EX_branch_taken) begin
        w_ctrl.if_id_flush = 1'b1;
        w_ctrl.id_ex_flush = 1'b1;
        w_flush_inc        = 1'b1;
      end else if (w_load_use) begin
        w_ctrl.pc_write    = 1'b0;
        w_ctrl.if_id_write = 1'b0;
        w_ctrl.id_ex_flush = 1'b1;
      end
    end
  end

  assign w_stall_inc = !rst && !w_ctrl.pc_write;

  assign PC_Write      = w_ctrl.pc_write;
  assign IF_ID_Write   = w_ctrl.if_id_write;
  assign ID_EX_Write   = w_ctrl.id_ex_write;
  assign EX_MEM_Write  = w_ctrl.ex_mem_write;
  assign IF_ID_Flush   = w_ctrl.if_id_flush;
  assign ID_EX_Flush   = w_ctrl.id_ex_flush;
  assign EX_MEM_Bubble = w_ctrl.ex_mem_bubble;
  assign MEM_WB_Bubble = w_ctrl.mem_wb_bubble;
  assign mdu_start     = w_ctrl.mdu_start;

  hazard_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk            (clk),
    .i_clr          (rst),
    .i_stall_inc    (w_stall_inc),
    .i_flush_inc    (w_flush_inc),
    .o_stall_cycles (stall_cycles),
    .o_flush_count  (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed per-cycle stimulus with expected
// controls and counters queued at drive time and compared mid-cycle.
module tb_hazard_ctrl;

  localparam int CNT_W = 8;

  // Control vector order: PC, IF_ID_W, ID_EX_W, EX_MEM_W, IF_ID_F, ID_EX_F,
  // EX_MEM_B, MEM_WB_B, mdu_start.
  localparam logic [8:0] C_DEF  = 9'b1111_0000_0;
  localparam logic [8:0] C_LU   = 9'b0011_0100_0;
  localparam logic [8:0] C_MST  = 9'b0001_0010_1;
  localparam logic [8:0] C_MBZ  = 9'b0001_0010_0;
  localparam logic [8:0] C_BR   = 9'b1111_1100_0;
  localparam logic [8:0] C_MW   = 9'b0000_0001_0;

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic       memread;
    logic [4:0] exrd;
    logic       is_mdu, done, br, dreq, drdy;
  } stim_t;

  typedef struct {
    string            tag;
    logic [8:0]       ctrl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       ID_rs1, ID_rs2, ID_EX_rd;
  logic             ID_uses_rs1, ID_uses_rs2, ID_EX_MemRead, ID_EX_is_mdu;
  logic             mdu_done, EX_branch_taken, dmem_req, dmem_ready;
  logic             PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
  logic             IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble, MEM_WB_Bubble, mdu_start;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  exp_t             sb_q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] e_stall = '0;
  logic [CNT_W-1:0] e_flush = '0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
    .ID_EX_is_mdu(ID_EX_is_mdu), .mdu_done(mdu_done),
    .EX_branch_taken(EX_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .ID_EX_Write(ID_EX_Write), .EX_MEM_Write(EX_MEM_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Bubble(EX_MEM_Bubble), .MEM_WB_Bubble(MEM_WB_Bubble),
    .mdu_start(mdu_start),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.rs1 = 5'd1; s.rs2 = 5'd2; s.u1 = 1'b0; s.u2 = 1'b0;
    s.memread = 1'b0; s.exrd = 5'd3; s.is_mdu = 1'b0; s.done = 1'b0;
    s.br = 1'b0; s.dreq = 1'b0; s.drdy = 1'b1;
    return s;
  endfunction

  // Load x5 in EX, add x6,x5,x7 in ID.
  function automatic stim_t load_use();
    stim_t s = idle();
    s.memread = 1'b1; s.exrd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
    s.rs2 = 5'd7; s.u2 = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; ID_rs1 = s.rs1; ID_rs2 = s.rs2;
    ID_uses_rs1 = s.u1; ID_uses_rs2 = s.u2; ID_EX_MemRead = s.memread;
    ID_EX_rd = s.exrd; ID_EX_is_mdu = s.is_mdu; mdu_done = s.done;
    EX_branch_taken = s.br; dmem_req = s.dreq; dmem_ready = s.drdy;
  endtask

  // One pipeline cycle: drive, queue expectation, compare at negedge, then
  // advance the expected counters across the coming edge.
  task automatic step(input string tag, input stim_t s, input logic [8:0] ec);
    exp_t e, g;
    drive(s);
    e.tag = tag; e.ctrl = ec; e.stall = e_stall; e.flush = e_flush;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      g = sb_q.pop_front();
      check({g.tag, ".ctrl"}, 32'({PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                                   IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble,
                                   MEM_WB_Bubble, mdu_start}), 32'(g.ctrl));
      check({g.tag, ".stall"}, 32'(stall_cycles), 32'(g.stall));
      check({g.tag, ".flush"}, 32'(flush_count), 32'(g.flush));
    end
    if (s.rst) begin
      e_stall = '0;
      e_flush = '0;
    end else begin
      if (!ec[8]) e_stall = e_stall + 1'b1;
      if (ec[4])  e_flush = e_flush + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    drive(s);
    repeat (2) @(posedge clk);
    #1;

    step("reset_hold", s, C_DEF);
    step("idle", idle(), C_DEF);

    // Load-use: one bubble, then forwarding covers the dependence.
    step("lu_rs1", load_use(), C_LU);
    step("lu_after", idle(), C_DEF);
    s = load_use(); s.exrd = 5'd0; s.rs1 = 5'd0;
    step("lu_x0", s, C_DEF);
    s = load_use(); s.u1 = 1'b0;
    step("lu_unused_rs1", s, C_DEF);
    s = load_use(); s.exrd = 5'd7; s.u1 = 1'b0;
    step("lu_rs2", s, C_LU);
    s = load_use(); s.memread = 1'b0;
    step("no_load", s, C_DEF);

    // MUL/DIV with done 4 cycles after start.
    s = idle(); s.is_mdu = 1'b1;
    step("mdu_start", s, C_MST);
    for (int i = 0; i < 3; i++) step($sformatf("mdu_busy%0d", i), s, C_MBZ);
    s.done = 1'b1;
    step("mdu_done", s, C_DEF);
    step("mdu_after", idle(), C_DEF);

    // Branch wins over a simultaneous load-use match.
    s = load_use(); s.br = 1'b1;
    step("branch_lu", s, C_BR);
    step("branch_after", idle(), C_DEF);

    // Memory wait in RUN masks a branch and its flush count.
    s = idle(); s.br = 1'b1; s.dreq = 1'b1; s.drdy = 1'b0;
    step("memwait_branch", s, C_MW);
    s = idle(); s.dreq = 1'b1; s.drdy = 1'b1;
    step("mem_ready", s, C_DEF);

    // Memory wait during MDU_BUSY with done arriving inside the wait.
    s = idle(); s.is_mdu = 1'b1;
    step("mdu2_start", s, C_MST);
    step("mdu2_busy", s, C_MBZ);
    s.dreq = 1'b1; s.drdy = 1'b0;
    step("mdu2_wait0", s, C_MW);
    s.done = 1'b1;
    step("mdu2_wait1_done", s, C_MW);
    s.done = 1'b0;
    step("mdu2_wait2", s, C_MW);
    s.drdy = 1'b1;
    step("mdu2_pend_release", s, C_DEF);
    step("mdu2_after", idle(), C_DEF);

    // Reset abandons MDU_BUSY; a late done in RUN is ignored.
    s = idle(); s.is_mdu = 1'b1;
    step("mdu3_start", s, C_MST);
    step("mdu3_busy", s, C_MBZ);
    s.rst = 1'b1;
    step("mdu3_reset", s, C_DEF);
    s = idle(); s.done = 1'b1;
    step("late_done", s, C_DEF);
    step("post_reset_lu", load_use(), C_LU);

    // Stall counter wraps modulo 2^CNT_W.
    while (e_stall != '1) step("fill", load_use(), C_LU);
    step("wrap_stall", load_use(), C_LU);
    step("wrapped", idle(), C_DEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

In-order pipeline hazard controller: the sequencing authority for the IF/ID/EX/MEM/WB pipeline registers and PC.
- Detects load-use hazards that operand forwarding cannot cover.
- Flushes on taken branches and jumps resolved in EX.
- Runs a start/done handshake with the multi-cycle MUL/DIV unit.
- Freezes the whole pipeline on data-memory wait states.
- Keeps stall and flush performance counters.

It sits beside the forwarding logic and drives the write-enable, flush and bubble controls of every pipeline register.

## Interface
Parameters:
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- ID_rs1, ID_rs2  in  5  source registers of the instruction in ID
- ID_uses_rs1, ID_uses_rs2  in  1  the ID instruction actually reads that source
- ID_EX_MemRead  in  1  the instruction in EX is a load
- ID_EX_rd  in  5  destination of the instruction in EX
- ID_EX_is_mdu  in  1  the instruction in EX is MUL/DIV
- mdu_done  in  1  one-cycle pulse: MUL/DIV result valid
- EX_branch_taken  in  1  taken branch or jump resolved in EX
- dmem_req, dmem_ready  in  1  MEM-stage access pending / completed
- PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write  out  1  register enables
- IF_ID_Flush, ID_EX_Flush  out  1  load a NOP bubble
- EX_MEM_Bubble, MEM_WB_Bubble  out  1  load a NOP bubble into that register
- mdu_start  out  1  one-cycle start pulse to MUL/DIV
- stall_cycles, flush_count  out  CNT_W  performance counters

## Operation
- FSM states: RUN, MDU_BUSY. One internal flag: done_pend.
- All outputs default to enables=1, flushes/bubbles=0, mdu_start=0.
- Outputs are combinational from state and inputs.
- Conditions are evaluated in the priority order below.

Priority order:
1. **MEM_WAIT** (dmem_req && !dmem_ready), any state:
   - All four *_Write=0, MEM_WB_Bubble=1.
   - All flushes, EX_MEM_Bubble and mdu_start forced 0; state held.
   - A mdu_done arriving during the wait sets done_pend.
2. **MDU_BUSY**:
   - PC_Write=IF_ID_Write=ID_EX_Write=0, EX_MEM_Bubble=1.
   - When (mdu_done || done_pend) and not MEM_WAIT: release the stall (all enables 1, EX_MEM_Bubble=0), clear done_pend, go to RUN.
3. **RUN with ID_EX_is_mdu**:
   - Same stall pattern as MDU_BUSY.
   - mdu_start=1 for exactly this cycle; next state MDU_BUSY.
   - mdu_done is never expected in the start cycle and is ignored there.
4. **RUN with EX_branch_taken**:
   - IF_ID_Flush=ID_EX_Flush=1, PC_Write=1 (PC loads the target).
   - flush_count increments.
   - Overrides load-use.
5. **RUN load-use**:
   - Condition: ID_EX_MemRead && ID_EX_rd!=0 && ((ID_uses_rs1 && ID_rs1==ID_EX_rd) || (ID_uses_rs2 && ID_rs2==ID_EX_rd)).
   - Response: PC_Write=IF_ID_Write=0, ID_EX_Flush=1.

Counters:
- stall_cycles increments every cycle PC_Write==0.
- Both counters wrap modulo 2^CNT_W.

Reset (rst=1 at a clock edge):
- state=RUN, done_pend=0, counters=0.
- While rst is high, outputs take their defaults; no counting.
- Reset during MDU_BUSY abandons the operation; a subsequent mdu_done in RUN is ignored.

## Timing
- Load-use: exactly one bubble cycle; in the next cycle the load sits in MEM and forwarding covers the dependence.
- MUL/DIV with N-cycle latency (mdu_done N cycles after mdu_start, N≥1): the pipeline is frozen N cycles and advances in the done cycle.
- A branch flush costs 2 bubbles. Flush signals are single-cycle.
- MEM_WAIT lasts exactly as long as dmem_ready is low, with zero added cycles. A done_pend set during the wait completes MDU_BUSY on the first non-wait cycle.
- mdu_start is never asserted twice for one instruction.

## Structure
- Shared package/header:
  - state encoding RUN=1'b0, MDU_BUSY=1'b1
  - NOP-bubble control constant
  - CNT_W default
- Natural sub-module: hazard_perf_counters (two wrapping counters with increment enables and synchronous clear), instantiated once.
- The FSM and priority logic stay in hazard_ctrl.

## Test plan
- Load x5, then add x6,x5,x7 in ID (ID_uses_rs1=1): one cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; stall_cycles 0→1.
- Same case with ID_EX_rd=0, or ID_uses_rs1=0: no stall.
- ID_EX_is_mdu=1, mdu_done 4 cycles after start: mdu_start pulses once; 4 frozen cycles with EX_MEM_Bubble=1; release in the done cycle; stall_cycles=4.
- EX_branch_taken together with a load-use match: IF_ID_Flush=ID_EX_Flush=1, PC_Write=1, no load-use stall; flush_count=1.
- During MDU_BUSY: dmem_ready low for 3 cycles with mdu_done pulsed in the 2nd cycle → MEM_WB_Bubble=1 for those 3 cycles, done_pend set, MDU released on the cycle after ready returns.
- rst asserted in MDU_BUSY, then mdu_done pulse: state RUN, no release anomaly, counters 0.
- Counter preloaded to 2^CNT_W−1 (via force), one stall → wraps to 0.
